// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (read-only) and data ports; IDLE/ISSUE/WAIT/RESP sequencing.
// Optional statistics counters are enabled by defining MEM_ARB_STATS_EN.
module mem_port_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [7:0]  if_addr,
    output logic        if_ready,
    output logic [18:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [7:0]  d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [8:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        if_stall,
    output logic        d_stall
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0] stat_conflicts,
    output logic [15:0] stat_forced
`endif
);
    localparam logic [2:0] LAT_LOAD   = 3'(MEM_LAT - 1);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;     // 1 = data port owns the access
    logic        own_we_q, own_we_d;
    logic [2:0]  lat_q, lat_d;
    logic [3:0]  starve_q, starve_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;
    logic [8:0]  mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        if_ready_q, if_ready_d;
    logic        d_ready_q, d_ready_d;
    logic [18:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        pick_fetch;
    logic        both_req;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] conflicts_q, conflicts_d;
    logic [15:0] forced_q, forced_d;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        own_we_d    = own_we_q;
        lat_d       = lat_q;
        starve_d    = starve_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        both_req    = if_req & d_req;
        pick_fetch  = if_req & (~d_req | (starve_q == STARVE_LIM));
`ifdef MEM_ARB_STATS_EN
        conflicts_d = conflicts_q;
        forced_d    = forced_q;
`endif
        case (state_q)
            IDLE: begin
                // The cycle after RESP still has ready high while the requester
                // holds req; it is only a new access if req stays high after that.
                if (!(if_ready_q || d_ready_q) && (if_req || d_req)) begin
                    owner_d     = ~pick_fetch;
                    own_we_d    = ~pick_fetch & d_we;
                    mem_en_d    = 1'b1;
                    mem_we_d    = ~pick_fetch & d_we;
                    mem_addr_d  = pick_fetch ? {1'b0, if_addr} : {1'b1, d_addr};
                    mem_wdata_d = pick_fetch ? 32'h0 : d_wdata;
                    if (pick_fetch) begin
                        starve_d = 4'd0;
                    end else if (if_req) begin
                        starve_d = starve_q + 4'd1;
                    end
`ifdef MEM_ARB_STATS_EN
                    if (both_req && conflicts_q != 16'hFFFF) begin
                        conflicts_d = conflicts_q + 16'd1;
                    end
                    if (both_req && pick_fetch && forced_q != 16'hFFFF) begin
                        forced_d = forced_q + 16'd1;
                    end
`endif
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                lat_d   = LAT_LOAD;
                state_d = (MEM_LAT == 1) ? RESP : WAIT;
            end
            WAIT: begin
                lat_d = lat_q - 3'd1;
                if (lat_q == 3'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (owner_q) begin
                    d_ready_d = 1'b1;
                    if (!own_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                end else begin
                    if_ready_d = 1'b1;
                    if_rdata_d = mem_rdata[18:0];
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            own_we_q    <= 1'b0;
            lat_q       <= 3'd0;
            starve_q    <= 4'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 9'd0;
            mem_wdata_q <= 32'd0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            if_rdata_q  <= 19'd0;
            d_rdata_q   <= 32'd0;
`ifdef MEM_ARB_STATS_EN
            conflicts_q <= 16'd0;
            forced_q    <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            own_we_q    <= own_we_d;
            lat_q       <= lat_d;
            starve_q    <= starve_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
`ifdef MEM_ARB_STATS_EN
            conflicts_q <= conflicts_d;
            forced_q    <= forced_d;
`endif
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_ready  = if_ready_q;
    assign d_ready   = d_ready_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_stall  = if_req & ~if_ready_q;
    assign d_stall   = d_req & ~d_ready_q;
`ifdef MEM_ARB_STATS_EN
    assign stat_conflicts = conflicts_q;
    assign stat_forced    = forced_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 has MEM_LAT=1, instance 1 has MEM_LAT=4; both STARVE_MAX=3.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst       [2];
    logic        if_req    [2];
    logic [7:0]  if_addr   [2];
    logic        if_ready  [2];
    logic [18:0] if_rdata  [2];
    logic        d_req     [2];
    logic        d_we      [2];
    logic [7:0]  d_addr    [2];
    logic [31:0] d_wdata   [2];
    logic        d_ready   [2];
    logic [31:0] d_rdata   [2];
    logic        mem_en    [2];
    logic        mem_we    [2];
    logic [8:0]  mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic        if_stall  [2];
    logic        d_stall   [2];
`ifdef MEM_ARB_STATS_EN
    logic [15:0] stat_c [2];
    logic [15:0] stat_f [2];
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(3)) u_a (
        .clk(clk), .reset(rst[0]),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_ready(if_ready[0]), .if_rdata(if_rdata[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
        .d_ready(d_ready[0]), .d_rdata(d_rdata[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0]), .if_stall(if_stall[0]), .d_stall(d_stall[0])
`ifdef MEM_ARB_STATS_EN
        , .stat_conflicts(stat_c[0]), .stat_forced(stat_f[0])
`endif
    );

    mem_port_arbiter #(.MEM_LAT(4), .STARVE_MAX(3)) u_b (
        .clk(clk), .reset(rst[1]),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_ready(if_ready[1]), .if_rdata(if_rdata[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
        .d_ready(d_ready[1]), .d_rdata(d_rdata[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1]), .if_stall(if_stall[1]), .d_stall(d_stall[1])
`ifdef MEM_ARB_STATS_EN
        , .stat_conflicts(stat_c[1]), .stat_forced(stat_f[1])
`endif
    );

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    // Default memory contents; region bit is folded in so the two regions differ.
    function automatic logic [31:0] f(input logic [8:0] a);
        if (a == 9'h005) return 32'h0007_ABCD;
        return 32'hA500_0000 ^ {7'b0, a, 16'b0} ^ {23'b0, a};
    endfunction

    // Memory model: read data becomes valid MEM_LAT cycles after the issue cycle.
    logic [31:0] mem   [2][512];
    bit          wr_ok [2][512];
    int          pcnt  [2];
    logic [31:0] pval  [2];

    function automatic logic [31:0] rdval(input int i, input logic [8:0] a);
        return wr_ok[i][a] ? mem[i][a] : f(a);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_en[i]) begin
                if (mem_we[i]) begin
                    mem[i][mem_addr[i]]   <= mem_wdata[i];
                    wr_ok[i][mem_addr[i]] <= 1'b1;
                end
                if (lat(i) == 1) begin
                    mem_rdata[i] <= rdval(i, mem_addr[i]);
                    pcnt[i]      <= 0;
                end else begin
                    mem_rdata[i] <= 32'hBAD0_BAD0;
                    pval[i]      <= rdval(i, mem_addr[i]);
                    pcnt[i]      <= lat(i) - 1;
                end
            end else if (pcnt[i] > 0) begin
                pcnt[i]      <= pcnt[i] - 1;
                mem_rdata[i] <= (pcnt[i] == 1) ? pval[i] : 32'hBAD0_BAD0;
            end
        end
    end

    typedef struct {
        int          inst;
        bit          is_d;
        logic [63:0] rdata;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        bit          is_d;
        bit          we;
        logic [7:0]  a;
        logic [31:0] wd;
        logic [31:0] rd;
    } vec_t;
    vec_t vt[8];

    logic [31:0] last_d [2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One complete access on instance i; returns one idle cycle after ready.
    task automatic do_access(input int i, input bit is_d, input bit we, input logic [7:0] a,
                             input logic [31:0] wd, input logic [31:0] exp_rd, input string nm);
        sb_t e;
        sb_t r;
        int  n;
        int  en_cnt;
        bit  got;
        e.inst  = i;
        e.is_d  = is_d;
        e.rdata = is_d ? (we ? {32'b0, last_d[i]} : {32'b0, exp_rd}) : {45'b0, exp_rd[18:0]};
        sb.push_back(e);
        if (is_d) begin
            d_req[i] = 1'b1; d_we[i] = we; d_addr[i] = a; d_wdata[i] = wd;
        end else begin
            if_req[i] = 1'b1; if_addr[i] = a;
        end
        n = 0; en_cnt = 0; got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (mem_en[i]) begin
                en_cnt++;
                chk({nm, "_addr"}, {55'b0, mem_addr[i]}, {55'b0, is_d, a});
                chk({nm, "_we"}, {63'b0, mem_we[i]}, {63'b0, we});
                if (we) chk({nm, "_wdata"}, {32'b0, mem_wdata[i]}, {32'b0, wd});
            end
            chk({nm, "_stall"}, {63'b0, (is_d ? d_stall[i] : if_stall[i])}, {63'b0, (n != lat(i) + 2)});
            if (is_d ? d_ready[i] : if_ready[i]) got = 1'b1;
        end
        chk({nm, "_ready_seen"}, {63'b0, got}, 64'd1);
        chk({nm, "_latency"}, 64'(n), 64'(lat(i) + 2));
        chk({nm, "_mem_en_cnt"}, 64'(en_cnt), 64'd1);
        r = sb.pop_front();
        if (r.is_d) chk({nm, "_rdata"}, {32'b0, d_rdata[r.inst]}, r.rdata);
        else        chk({nm, "_rdata"}, {45'b0, if_rdata[r.inst]}, r.rdata);
        if (is_d && !we) last_d[i] = exp_rd;
        d_req[i] = 1'b0; if_req[i] = 1'b0;
        @(negedge clk);
    endtask

    task automatic reset_inst(input int i);
        rst[i] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst[i] = 1'b0;
        last_d[i] = 32'h0;
    endtask

    initial begin
        bit gq[$];
        int cyc;
        int grants;
        int fetch_issue;
        int en_cnt;
        int rdy_cnt;
        bit exp_rdy;

        vt[0] = '{1'b0, 1'b0, 8'h05, 32'h0,         32'h0007_ABCD};
        vt[1] = '{1'b1, 1'b1, 8'h10, 32'hDEADBEEF,  32'h0};
        vt[2] = '{1'b1, 1'b0, 8'h10, 32'h0,         32'hDEADBEEF};
        vt[3] = '{1'b0, 1'b0, 8'hFF, 32'h0,         f(9'h0FF)};
        vt[4] = '{1'b1, 1'b0, 8'h00, 32'h0,         f(9'h100)};
        vt[5] = '{1'b1, 1'b1, 8'hFF, 32'h1234_5678, 32'h0};
        vt[6] = '{1'b1, 1'b0, 8'hFF, 32'h0,         32'h1234_5678};
        vt[7] = '{1'b0, 1'b0, 8'hFF, 32'h0,         f(9'h0FF)};

        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; if_req[i] = 1'b0; if_addr[i] = 8'h0; d_req[i] = 1'b0;
            d_we[i] = 1'b0; d_addr[i] = 8'h0; d_wdata[i] = 32'h0; last_d[i] = 32'h0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_ctrl", {18'b0, mem_en[i], mem_we[i], mem_addr[i], mem_wdata[i], if_ready[i], d_ready[i]}, 64'd0);
            chk("reset_rdata", {13'b0, if_rdata[i], d_rdata[i]}, 64'd0);
            rst[i] = 1'b0;
        end
        @(negedge clk);

        for (int k = 0; k < 8; k++)
            do_access(0, vt[k].is_d, vt[k].we, vt[k].a, vt[k].wd, vt[k].rd, $sformatf("vec%0d", k));

        do_access(1, 1'b1, 1'b0, 8'h22, 32'h0, f(9'h122), "lat4_read");
        do_access(1, 1'b0, 1'b0, 8'h05, 32'h0, 32'h0007_ABCD, "lat4_fetch");

        // Reset during WAIT, with a new fetch request raised in the same cycle as reset.
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 8'h33;
        @(negedge clk);
        @(negedge clk);
        rst[1] = 1'b1; if_req[1] = 1'b1; if_addr[1] = 8'h44;
        @(negedge clk);
        chk("rstwait_ctrl", {18'b0, mem_en[1], mem_we[1], mem_addr[1], mem_wdata[1], if_ready[1], d_ready[1]}, 64'd0);
        chk("rstwait_rdata", {13'b0, if_rdata[1], d_rdata[1]}, 64'd0);
        rst[1] = 1'b0; if_req[1] = 1'b0; d_req[1] = 1'b0; last_d[1] = 32'h0;
        en_cnt = 0; rdy_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (mem_en[1]) en_cnt++;
            if (if_ready[1] || d_ready[1]) rdy_cnt++;
        end
        chk("rstwait_no_issue", 64'(en_cnt), 64'd0);
        chk("rstwait_no_ready", 64'(rdy_cnt), 64'd0);
        do_access(1, 1'b1, 1'b0, 8'h33, 32'h0, f(9'h133), "post_reset_read");

        // Continuous contention on instance 0: expected grants D,D,D,I,D,D,D,I.
        reset_inst(0);
        gq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        if_req[0] = 1'b1; if_addr[0] = 8'h05;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 8'h20;
        cyc = 0; grants = 0; fetch_issue = -100;
        while (cyc < 200 && !(grants == 8 && cyc == fetch_issue + lat(0) + 1)) begin
            @(negedge clk);
            cyc++;
            exp_rdy = (cyc == fetch_issue + lat(0) + 1);
            chk("cont_if_ready", {63'b0, if_ready[0]}, {63'b0, exp_rdy});
            chk("cont_if_stall", {63'b0, if_stall[0]}, {63'b0, ~exp_rdy});
            if (mem_en[0]) begin
                if (gq.size() == 0) begin
                    chk("cont_extra_grant", 64'(grants), 64'd8);
                end else begin
                    chk($sformatf("cont_grant%0d", grants), {63'b0, mem_addr[0][8]}, {63'b0, gq.pop_front()});
                end
                if (!mem_addr[0][8]) fetch_issue = cyc;
                grants++;
            end
        end
        if_req[0] = 1'b0; d_req[0] = 1'b0;
        chk("cont_done", 64'(grants), 64'd8);
        chk("cont_if_rdata", {45'b0, if_rdata[0]}, 64'h7ABCD);
        chk("cont_d_rdata", {32'b0, d_rdata[0]}, {32'b0, f(9'h120)});
        @(negedge clk);
        @(negedge clk);
`ifdef MEM_ARB_STATS_EN
        chk("stat_conflicts", {48'b0, stat_c[0]}, 64'd8);
        chk("stat_forced", {48'b0, stat_f[0]}, 64'd2);
`endif
        chk("cont_quiet", {63'b0, mem_en[0]}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
